// File: rtl/bin_to_bcd_stage.sv
// Sequential double-dabble converter: 13-bit binary to four BCD digits, with a
// one-entry pending buffer so back-to-back requests from the upstream engine are not lost.
module bin_to_bcd_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] bin,
  output logic        ready,
  output logic        done_tick,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0
);

  typedef enum logic [1:0] {IDLE = 2'd0, OP = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [12:0] shift_q;
  logic [15:0] work_q;
  logic [3:0]  cnt_q;
  logic        pend_q;
  logic [12:0] pend_val_q;

  logic [15:0] work_adj;
  logic        load_go;
  logic [12:0] load_val;
  logic        capture;
  logic        consumed;

  // +3 only on nibbles >= 5, so a nibble never exceeds 12 before the shift
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  // Pending entry has priority over a fresh start; a start that cannot be
  // loaded directly lands in the pending buffer (last one wins).
  always_comb begin
    load_go  = 1'b0;
    load_val = bin;
    case (state)
      IDLE: begin
        load_go  = pend_q | start;
        load_val = pend_q ? pend_val_q : bin;
      end
      DONE: begin
        load_go  = pend_q;
        load_val = pend_val_q;
      end
      default: ;
    endcase
    capture  = start && ((state != IDLE) || pend_q);
    consumed = load_go && pend_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd3       <= '0;
      bcd2       <= '0;
      bcd1       <= '0;
      bcd0       <= '0;
    end else begin
      if (capture) begin
        pend_q     <= 1'b1;
        pend_val_q <= bin;
      end else if (consumed) begin
        pend_q     <= 1'b0;
      end

      if (load_go) begin
        shift_q <= load_val;
        work_q  <= '0;
        cnt_q   <= 4'd13;
      end

      case (state)
        IDLE: if (load_go) state <= OP;
        OP: begin
          if (cnt_q == 4'd0) begin
            state <= DONE;
            {bcd3, bcd2, bcd1, bcd0} <= work_q;
          end else begin
            {work_q, shift_q} <= {work_adj[14:0], shift_q, 1'b0};
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state <= load_go ? OP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == IDLE) && !pend_q;
  assign done_tick = (state == DONE);

endmodule
